// File: rtl/idli_pkg.sv
// Shared SQI responder definitions: instruction codes, FSM states, frame field lengths.
package idli_pkg;

  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } sqi_rsp_state_t;

  localparam int unsigned SQI_CMD_NIBBLES   = 2;
  localparam int unsigned SQI_ADDR_NIBBLES  = 4;
  localparam int unsigned SQI_DUMMY_NIBBLES = 2;
  localparam int unsigned SQI_BYTE_NIBBLES  = 2;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Single-port byte RAM: synchronous write, asynchronous read. Contents are not reset.
module idli_sqi_ram_m #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // Byte write on the clock edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/idli_sqi_rsp_m.sv
// SQI SRAM responder: decodes instruction/address/data nibbles from the core
// and serves sequential reads and writes out of an internal byte RAM.
module idli_sqi_rsp_m
  import idli_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic       i_sqi_gck,
  input  logic       i_sqi_rst,
  input  logic       i_sqi_sck,
  input  logic       i_sqi_cs,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_oe
);

  sqi_rsp_state_t state, state_nxt;

  logic              sck_q;
  logic              cs_q;
  logic              rise;
  logic              fall;
  logic [1:0]        cnt;
  logic [11:0]       sr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]        rbuf;
  logic              half;
  logic              is_read;
  logic [7:0]        cmd_byte;
  logic [15:0]       addr_full;
  logic              addr_full_unused;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  assign rise      = i_sqi_sck & ~sck_q;
  assign fall      = ~i_sqi_sck & sck_q;
  assign cmd_byte  = {sr[3:0], i_sqi_sio};
  assign addr_full = {sr, i_sqi_sio};
  assign addr_inc  = addr + ADDR_W'(1);
  // Upper address bits beyond ADDR_W are deliberately dropped.
  assign addr_full_unused = ^addr_full;

  idli_sqi_ram_m #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (i_sqi_gck),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus RAM port control.
  // During RDATA the RAM looks one byte ahead so the preload on the low-nibble fall sees addr+1.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = addr;
    ram_wdata = cmd_byte;
    if (i_sqi_cs) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cs_q) begin
            state_nxt = CMD;
          end
        end
        CMD: begin
          if (rise && cnt == 2'(SQI_CMD_NIBBLES - 1)) begin
            case (cmd_byte)
              SQI_CMD_READ, SQI_CMD_WRITE: state_nxt = ADDR;
              default:                     state_nxt = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (rise && cnt == 2'(SQI_ADDR_NIBBLES - 1)) begin
            state_nxt = is_read ? DUMMY : WDATA;
          end
        end
        DUMMY: begin
          if (rise && cnt == 2'(SQI_DUMMY_NIBBLES - 1)) begin
            state_nxt = RDATA;
          end
        end
        RDATA: begin
          ram_addr = addr_inc;
        end
        WDATA: begin
          if (rise && cnt == 2'(SQI_BYTE_NIBBLES - 1)) begin
            ram_we = 1'b1;
          end
        end
        IGNORE: begin
          state_nxt = IGNORE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Datapath: edge detect, nibble shifting, address tracking and read output.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      // cs_q clears so a still-low cs after reset is not taken as a new frame start.
      sck_q        <= 1'b0;
      cs_q         <= 1'b0;
      cnt          <= '0;
      sr           <= '0;
      addr         <= '0;
      rbuf         <= '0;
      half         <= 1'b0;
      is_read      <= 1'b0;
      o_sqi_sio    <= '0;
      o_sqi_sio_oe <= 1'b0;
    end else begin
      sck_q <= i_sqi_sck;
      cs_q  <= i_sqi_cs;
      if (i_sqi_cs) begin
        o_sqi_sio_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt  <= '0;
            half <= 1'b0;
          end
          CMD: begin
            if (rise) begin
              sr <= {sr[7:0], i_sqi_sio};
              if (cnt == 2'(SQI_CMD_NIBBLES - 1)) begin
                cnt     <= '0;
                is_read <= (cmd_byte == SQI_CMD_READ);
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              sr <= {sr[7:0], i_sqi_sio};
              if (cnt == 2'(SQI_ADDR_NIBBLES - 1)) begin
                cnt  <= '0;
                addr <= addr_full[ADDR_W-1:0];
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
          end
          DUMMY: begin
            if (rise) begin
              if (cnt == 2'(SQI_DUMMY_NIBBLES - 1)) begin
                cnt  <= '0;
                rbuf <= ram_rdata;
                half <= 1'b0;
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
          end
          RDATA: begin
            if (fall) begin
              o_sqi_sio_oe <= 1'b1;
              if (!half) begin
                o_sqi_sio <= rbuf[7:4];
                half      <= 1'b1;
              end else begin
                o_sqi_sio <= rbuf[3:0];
                half      <= 1'b0;
                addr      <= addr_inc;
                rbuf      <= ram_rdata;
              end
            end
          end
          WDATA: begin
            if (rise) begin
              sr <= {sr[7:0], i_sqi_sio};
              if (cnt == 2'(SQI_BYTE_NIBBLES - 1)) begin
                cnt  <= '0;
                addr <= addr_inc;
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idli_sqi_rsp_m.sv
// Self-checking bench for idli_sqi_rsp_m: frame-level memory model plus per-cycle output compare.
module tb_idli_sqi_rsp_m;

  logic       gck;
  logic       rst;
  logic       sck;
  logic       cs;
  logic [3:0] sio_i;
  logic [3:0] o_sio;
  logic       o_oe;

  int unsigned checks;
  int unsigned errors;
  int unsigned oe_hits;
  bit          chk_en;

  logic [7:0]  mem_m [256];
  logic        exp_oe;
  logic [3:0]  exp_sio;
  logic [7:0]  rd_base;
  int unsigned rd_k;
  logic [3:0]  seen [$];
  logic [7:0]  wq [$];

  idli_sqi_rsp_m #(.ADDR_W(8)) dut (
    .i_sqi_gck    (gck),
    .i_sqi_rst    (rst),
    .i_sqi_sck    (sck),
    .i_sqi_cs     (cs),
    .i_sqi_sio    (sio_i),
    .o_sqi_sio    (o_sio),
    .o_sqi_sio_oe (o_oe)
  );

  initial begin
    gck = 1'b0;
    forever #5 gck = ~gck;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled away from the active edge.
  always @(negedge gck) begin
    if (chk_en) begin
      chk("oe", 8'(o_oe), 8'(exp_oe));
      chk("sio", 8'(o_sio), 8'(exp_sio));
      if (o_oe === 1'b1) oe_hits++;
    end
  end

  task automatic step();
    @(posedge gck);
    #1;
  endtask

  // One sck period: rise (core drives n), then fall (responder may present a nibble).
  task automatic slot(input logic [3:0] n, input bit rd_out);
    logic [7:0] b;
    sio_i = n;
    sck = 1'b1;
    step();
    step();
    sck = 1'b0;
    step();
    if (rd_out) begin
      b = mem_m[8'(rd_base + 8'(rd_k / 2))];
      exp_oe  = 1'b1;
      exp_sio = (rd_k % 2 == 0) ? b[7:4] : b[3:0];
      rd_k++;
      seen.push_back(o_sio);
    end
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    slot(b[7:4], 1'b0);
    slot(b[3:0], 1'b0);
  endtask

  task automatic frame_begin();
    cs = 1'b0;
    step();
    step();
  endtask

  task automatic frame_end(input int unsigned gap);
    cs = 1'b1;
    step();
    exp_oe = 1'b0;
    for (int i = 1; i < int'(gap); i++) step();
  endtask

  task automatic write_frame(input logic [15:0] a, input bit part, input logic [3:0] pn,
                             input int unsigned gap);
    frame_begin();
    send_byte(8'h02);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < wq.size(); i++) begin
      send_byte(wq[i]);
      mem_m[8'(a[7:0] + 8'(i))] = wq[i];
    end
    if (part) slot(pn, 1'b0);
    frame_end(gap);
  endtask

  task automatic read_frame(input logic [15:0] a, input int unsigned nbytes, input int unsigned gap);
    frame_begin();
    send_byte(8'h03);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    slot(4'h0, 1'b0);
    chk("pre_data_oe", 8'(o_oe), 8'h00);
    rd_base = a[7:0];
    rd_k    = 0;
    seen.delete();
    slot(4'h0, 1'b1);
    for (int i = 0; i < int'(2 * nbytes); i++) slot(4'h0, 1'b1);
    frame_end(gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    oe_hits = 0;
    chk_en  = 0;
    rst     = 1'b1;
    cs      = 1'b1;
    sck     = 1'b0;
    sio_i   = 4'h0;
    exp_oe  = 1'b0;
    exp_sio = 4'h0;
    rd_base = 8'h00;
    rd_k    = 0;
    repeat (3) @(posedge gck);
    #1;
    rst    = 1'b0;
    chk_en = 1;
    chk("reset_oe", 8'(o_oe), 8'h00);
    chk("reset_sio", 8'(o_sio), 8'h00);
    step();

    // Known background contents for the whole array.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(8'(i) ^ 8'h5A);
    write_frame(16'h0000, 1'b0, 4'h0, 2);

    // Basic write then read.
    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
    write_frame(16'h0010, 1'b0, 4'h0, 2);
    read_frame(16'h0010, 2, 2);
    chk("rd10_n0", 8'(seen[0]), 8'h0A);
    chk("rd10_n1", 8'(seen[1]), 8'h05);
    chk("rd10_n2", 8'(seen[2]), 8'h03);
    chk("rd10_n3", 8'(seen[3]), 8'h0C);

    // Address wrap at the top of the array; upper bus bits ignored.
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    write_frame(16'h00FF, 1'b0, 4'h0, 2);
    read_frame(16'h00FF, 2, 2);
    chk("wrap_n0", 8'(seen[0]), 8'h01);
    chk("wrap_n1", 8'(seen[1]), 8'h01);
    chk("wrap_n2", 8'(seen[2]), 8'h02);
    chk("wrap_n3", 8'(seen[3]), 8'h02);
    read_frame(16'hAB00, 1, 2);
    chk("mem00_hi", 8'(seen[0]), 8'h02);
    chk("mem00_lo", 8'(seen[1]), 8'h02);

    // Unknown instruction: no drive, no writes.
    oe_hits = 0;
    frame_begin();
    send_byte(8'h05);
    repeat (8) slot(4'hF, 1'b0);
    frame_end(2);
    chk("ignore_oe_hits", 8'(oe_hits), 8'h00);
    read_frame(16'h00FF, 1, 2);
    chk("ignore_ff_hi", 8'(seen[0]), 8'h01);
    chk("ignore_ff_lo", 8'(seen[1]), 8'h01);

    // Partial trailing nibble is dropped.
    wq.delete(); wq.push_back(8'h77);
    write_frame(16'h0020, 1'b1, 4'h9, 2);
    read_frame(16'h0020, 2, 2);
    chk("part_n0", 8'(seen[0]), 8'h07);
    chk("part_n1", 8'(seen[1]), 8'h07);
    chk("part_n2", 8'(seen[2]), 8'h07);
    chk("part_n3", 8'(seen[3]), 8'h0B);

    // Reset in the middle of a read data phase.
    frame_begin();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h10);
    slot(4'h0, 1'b0);
    rd_base = 8'h10;
    rd_k    = 0;
    seen.delete();
    repeat (3) slot(4'h0, 1'b1);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    exp_oe  = 1'b0;
    exp_sio = 4'h0;
    chk("midrst_oe", 8'(o_oe), 8'h00);
    chk("midrst_sio", 8'(o_sio), 8'h00);
    oe_hits = 0;
    repeat (6) slot(4'hF, 1'b0);
    frame_end(2);
    chk("midrst_hits", 8'(oe_hits), 8'h00);
    read_frame(16'h0010, 2, 2);
    chk("postrst_n0", 8'(seen[0]), 8'h0A);
    chk("postrst_n3", 8'(seen[3]), 8'h0C);

    // Back-to-back frames, cs high for a single gck after a partial nibble.
    wq.delete(); wq.push_back(8'h12);
    write_frame(16'h0040, 1'b1, 4'hE, 1);
    read_frame(16'h0040, 1, 2);
    chk("b2b_n0", 8'(seen[0]), 8'h01);
    chk("b2b_n1", 8'(seen[1]), 8'h02);
    chk("b2b_n2", 8'(seen[2]), 8'h01);

    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idli_sqi_rsp_m.md
# idli_sqi_rsp_m

Synthesizable SQI (quad-SPI) SRAM responder: the device end of the memory bus that the idli core drives through its `sck`/`cs`/`sio` pins. It decodes instruction, 16-bit address and data nibbles, and serves sequential reads and writes from an internal byte array. It is used as an on-chip memory stand-in for integration and FPGA bring-up, and as the bus partner in core testbenches.

## Interface
- `ADDR_W`, default 8: implemented address bits. Storage is 2^ADDR_W bytes. Upper bits of the 16-bit bus address are ignored.
- `i_sqi_gck` in 1: system clock. Everything is registered on its rising edge.
- `i_sqi_rst` in 1: reset, synchronous, active-high.
- `i_sqi_sck` in 1: SQI serial clock from the core. It is synchronous to `i_sqi_gck`, and its high and low phases each last ≥2 gck cycles.
- `i_sqi_cs` in 1: chip select, active-low.
- `i_sqi_sio` in 4: nibble from the core.
- `o_sqi_sio` out 4: nibble to the core.
- `o_sqi_sio_oe` out 1: 1 while the responder drives `o_sqi_sio`.

## Operation
- `sck_q` registers `i_sqi_sck`.
  - Rise event: `i_sqi_sck & ~sck_q`. Sample `i_sqi_sio`.
  - Fall event: `~i_sqi_sck & sck_q`. Update `o_sqi_sio`.
- Events are acted on only while `i_sqi_cs == 0`.
- Nibble order within every byte is high nibble first. Multi-byte fields are MSB first.
- The frame is:
  - instruction: 2 nibbles;
  - address: 4 nibbles;
  - for reads only, dummy: 2 nibbles;
  - data: unbounded.
- Instructions: `0x03` READ, `0x02` WRITE. Any other value goes to IGNORE.
- FSM states:
  - IDLE: leave when `cs` falls. Clear the nibble counter, go to CMD.
  - CMD: after 2 rises, decode. READ/WRITE → ADDR; other → IGNORE.
  - ADDR: after 4 rises, latch `addr[ADDR_W-1:0]`. READ → DUMMY; WRITE → WDATA.
  - DUMMY: 2 rises, sampled values discarded. At the 2nd rise, preload the read byte `mem[addr]` into the shift register, then → RDATA.
  - RDATA:
    - Each fall outputs the next nibble (high, then low) and sets `oe = 1`.
    - After the low nibble's fall, `addr` increments and the next byte is preloaded.
  - WDATA: 2 rises assemble a byte. On the 2nd rise, write `mem[addr]` and increment `addr`.
  - IGNORE: stay until `cs` rises. No drive, no writes.
- `cs` high, in any state and on any cycle: next state IDLE, `oe = 0`. A partially received write byte is discarded, with no write.
- Address increment wraps modulo 2^ADDR_W, so 0xFF → 0x00 for `ADDR_W = 8`.
- Reset:
  - state IDLE;
  - `o_sqi_sio = 4'h0`;
  - `o_sqi_sio_oe = 0`;
  - nibble counter, address and shift registers cleared.
  - Memory contents are not reset.
- Reset mid-frame behaves as `cs` high. The responder waits in IDLE for the next `cs` falling edge and ignores the rest of the current frame, even though `cs` is still low.

## Timing
- Input sample: a rise event is seen one gck cycle after `i_sqi_sck` goes high. `i_sqi_sio` must be stable on that gck edge.
- Read output: `o_sqi_sio`/`oe` update on the gck edge that detects the fall, i.e. 1 gck after `sck` goes low. They are valid to the core on the following `sck` rise.
- First read nibble appears on the fall following the 2nd dummy rise. No other drive happens before it.
- Write commit: `mem` is updated on the gck edge that detects the 2nd data rise. The new value is readable by a READ frame starting ≥1 gck later.
- Deassert: `oe` falls on the first gck edge where `cs == 1` is sampled.

## Structure
- In `idli_pkg`:
  - `idli_pkg::sqi_cmd_t` constants `SQI_CMD_READ = 8'h03`, `SQI_CMD_WRITE = 8'h02`;
  - `sqi_rsp_state_t` enum with IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE;
  - `SQI_ADDR_NIBBLES = 4`, `SQI_DUMMY_NIBBLES = 2`.
- Sub-module `idli_sqi_ram_m`: single-port byte RAM, synchronous write, asynchronous read, parameter `ADDR_W`. Keeps the storage swappable for an FPGA BRAM.

## Test plan
- WRITE, addr `0x0010`, data `A5 3C`, then READ `0x0010` for 2 bytes → nibbles `A,5,3,C` on `o_sqi_sio` with `oe = 1`; `oe = 0` before the first data fall.
- WRITE `0x00FF` data `11 22`, then READ `0x00FF` for 2 bytes (`ADDR_W = 8`) → `11` then `22`, and `mem[0x00] == 0x22` (wrap).
- Instruction `0x05` followed by 8 nibbles of `F` → `oe` stays 0 and memory is unchanged; the next valid READ frame works.
- WRITE `0x0020` with 1 full byte `0x77` plus 1 nibble `0x9`, then `cs` high → `mem[0x20] = 0x77`, `mem[0x21]` unchanged.
- Reset asserted mid-RDATA → `oe = 0` and `sio = 0` on the next gck; remaining `sck` pulses of that frame are ignored. A new frame after `cs` toggles reads correctly.
- Back-to-back frames with `cs` high for 1 gck → the second frame decodes from CMD with no leftover nibble count.
